// File: rtl/arm7tdmi_decoder_if.sv
// Fetch-to-decode-to-execute bundle for the ARM7TDMI decode stage.
// The master side drives the fetched word and control signals. The slave (decoder) side drives the decoded fields.
interface arm7tdmi_decoder_if;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic        instr_valid;
    logic        stall;
    logic        flush;
    logic        thumb_mode;

    logic [3:0]  condition;
    logic [3:0]  instr_type;
    logic [3:0]  alu_op;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [11:0] immediate;
    logic        imm_en;
    logic        set_flags;
    logic [1:0]  shift_type;
    logic [4:0]  shift_amount;
    logic        shift_reg;
    logic [3:0]  shift_rs;
    logic        is_branch;
    logic        branch_link;
    logic [23:0] branch_offset;
    logic        is_memory;
    logic        mem_load;
    logic        mem_byte;
    logic        mem_pre;
    logic        mem_up;
    logic        mem_writeback;
    logic        psr_to_reg;
    logic        psr_spsr;
    logic        psr_immediate;
    logic [2:0]  cp_op;
    logic [3:0]  cp_num;
    logic [3:0]  cp_rd;
    logic [3:0]  cp_rn;
    logic [2:0]  cp_opcode1;
    logic [2:0]  cp_opcode2;
    logic        cp_load;
    logic [4:0]  thumb_instr_type;
    logic [2:0]  thumb_rd;
    logic [2:0]  thumb_rs;
    logic [2:0]  thumb_rn;
    logic [7:0]  thumb_imm8;
    logic [4:0]  thumb_imm5;
    logic [10:0] thumb_offset11;
    logic [7:0]  thumb_offset8;
    logic [31:0] pc_out;
    logic        decode_valid;

    modport master (
        output instruction, pc_in, instr_valid, stall, flush, thumb_mode,
        input  condition, instr_type, alu_op, rd, rn, rm, immediate, imm_en, set_flags,
               shift_type, shift_amount, shift_reg, shift_rs,
               is_branch, branch_link, branch_offset,
               is_memory, mem_load, mem_byte, mem_pre, mem_up, mem_writeback,
               psr_to_reg, psr_spsr, psr_immediate,
               cp_op, cp_num, cp_rd, cp_rn, cp_opcode1, cp_opcode2, cp_load,
               thumb_instr_type, thumb_rd, thumb_rs, thumb_rn,
               thumb_imm8, thumb_imm5, thumb_offset11, thumb_offset8,
               pc_out, decode_valid
    );

    modport slave (
        input  instruction, pc_in, instr_valid, stall, flush, thumb_mode,
        output condition, instr_type, alu_op, rd, rn, rm, immediate, imm_en, set_flags,
               shift_type, shift_amount, shift_reg, shift_rs,
               is_branch, branch_link, branch_offset,
               is_memory, mem_load, mem_byte, mem_pre, mem_up, mem_writeback,
               psr_to_reg, psr_spsr, psr_immediate,
               cp_op, cp_num, cp_rd, cp_rn, cp_opcode1, cp_opcode2, cp_load,
               thumb_instr_type, thumb_rd, thumb_rs, thumb_rn,
               thumb_imm8, thumb_imm5, thumb_offset11, thumb_offset8,
               pc_out, decode_valid
    );
endinterface

// File: rtl/arm7tdmi_decoder.sv
// ARM7TDMI registered decode stage. It classifies an ARM word, or a Thumb halfword, and registers the extracted fields.
// The priority is flush > stall > load. Every output is driven from the single output register q.
module arm7tdmi_decoder (
    input  logic                     clk,
    input  logic                     rst_n,
    arm7tdmi_decoder_if.slave        bus
);
    typedef enum logic [3:0] {
        C_DATA_PROC    = 4'd0,
        C_MUL          = 4'd1,
        C_MUL_LONG     = 4'd2,
        C_SWAP         = 4'd3,
        C_BRANCH_EX    = 4'd4,
        C_HALFWORD_DT  = 4'd5,
        C_SINGLE_DT    = 4'd6,
        C_UNDEFINED    = 4'd7,
        C_BLOCK_DT     = 4'd8,
        C_BRANCH       = 4'd9,
        C_COPROC_DT    = 4'd10,
        C_COPROC_OP    = 4'd11,
        C_COPROC_RT    = 4'd12,
        C_SWI          = 4'd13,
        C_PSR_TRANSFER = 4'd14
    } arm_class_e;

    typedef enum logic [4:0] {
        T_SHIFT_IMM = 5'd0,  T_ADD_SUB  = 5'd1,  T_IMM_OP   = 5'd2,  T_ALU      = 5'd3,
        T_HI_REG    = 5'd4,  T_PC_LOAD  = 5'd5,  T_REG_OFS  = 5'd6,  T_SIGN_EXT = 5'd7,
        T_IMM_LDST  = 5'd8,  T_HALFWORD = 5'd9,  T_SP_REL   = 5'd10, T_LOAD_ADR = 5'd11,
        T_SP_ADJ    = 5'd12, T_PUSH_POP = 5'd13, T_LDM_STM  = 5'd14, T_COND_BR  = 5'd15,
        T_SWI       = 5'd16, T_B        = 5'd17, T_BL       = 5'd18, T_NONE     = 5'd31
    } thumb_class_e;

    typedef struct packed {
        logic [3:0]  condition;
        logic [3:0]  instr_type;
        logic [3:0]  alu_op;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [11:0] immediate;
        logic        imm_en;
        logic        set_flags;
        logic [1:0]  shift_type;
        logic [4:0]  shift_amount;
        logic        shift_reg;
        logic [3:0]  shift_rs;
        logic        is_branch;
        logic        branch_link;
        logic [23:0] branch_offset;
        logic        is_memory;
        logic        mem_load;
        logic        mem_byte;
        logic        mem_pre;
        logic        mem_up;
        logic        mem_writeback;
        logic        psr_to_reg;
        logic        psr_spsr;
        logic        psr_immediate;
        logic [2:0]  cp_op;
        logic [3:0]  cp_num;
        logic [3:0]  cp_rd;
        logic [3:0]  cp_rn;
        logic [2:0]  cp_opcode1;
        logic [2:0]  cp_opcode2;
        logic        cp_load;
        logic [4:0]  thumb_instr_type;
        logic [2:0]  thumb_rd;
        logic [2:0]  thumb_rs;
        logic [2:0]  thumb_rn;
        logic [7:0]  thumb_imm8;
        logic [4:0]  thumb_imm5;
        logic [10:0] thumb_offset11;
        logic [7:0]  thumb_offset8;
        logic [31:0] pc_out;
        logic        decode_valid;
    } dec_t;

    logic [31:0]  ins;
    logic [15:0]  hw;
    arm_class_e   arm_cls;
    thumb_class_e thm_cls;
    dec_t         d;
    dec_t         q;

    assign ins = bus.instruction;
    assign hw  = bus.instruction[15:0];

    // ARM class rules are evaluated in order, and the first match wins.
    always_comb begin
        if (ins[27:4] == 24'h12FFF1)                                         arm_cls = C_BRANCH_EX;
        else if (ins[27:22] == 6'b000000 && ins[7:4] == 4'b1001)             arm_cls = C_MUL;
        else if (ins[27:23] == 5'b00001 && ins[7:4] == 4'b1001)              arm_cls = C_MUL_LONG;
        else if (ins[27:23] == 5'b00010 && ins[21:20] == 2'b00 &&
                 ins[11:4] == 8'b0000_1001)                                  arm_cls = C_SWAP;
        else if (ins[27:25] == 3'b000 && ins[7] && ins[4])                   arm_cls = C_HALFWORD_DT;
        else if (ins[27:26] == 2'b00 && ins[24:23] == 2'b10 && !ins[20])     arm_cls = C_PSR_TRANSFER;
        else if (ins[27:26] == 2'b00)                                        arm_cls = C_DATA_PROC;
        else if (ins[27:25] == 3'b011 && ins[4])                             arm_cls = C_UNDEFINED;
        else if (ins[27:26] == 2'b01)                                        arm_cls = C_SINGLE_DT;
        else if (ins[27:25] == 3'b100)                                       arm_cls = C_BLOCK_DT;
        else if (ins[27:25] == 3'b101)                                       arm_cls = C_BRANCH;
        else if (ins[27:25] == 3'b110)                                       arm_cls = C_COPROC_DT;
        else if (!ins[24])                                                   arm_cls = ins[4] ? C_COPROC_RT : C_COPROC_OP;
        else                                                                 arm_cls = C_SWI;
    end

    always_comb begin
        if (hw[15:11] == 5'b00011)                               thm_cls = T_ADD_SUB;
        else if (hw[15:13] == 3'b000)                            thm_cls = T_SHIFT_IMM;
        else if (hw[15:13] == 3'b001)                            thm_cls = T_IMM_OP;
        else if (hw[15:10] == 6'b010000)                         thm_cls = T_ALU;
        else if (hw[15:10] == 6'b010001)                         thm_cls = T_HI_REG;
        else if (hw[15:11] == 5'b01001)                          thm_cls = T_PC_LOAD;
        else if (hw[15:12] == 4'b0101)                           thm_cls = hw[9] ? T_SIGN_EXT : T_REG_OFS;
        else if (hw[15:13] == 3'b011)                            thm_cls = T_IMM_LDST;
        else if (hw[15:12] == 4'b1000)                           thm_cls = T_HALFWORD;
        else if (hw[15:12] == 4'b1001)                           thm_cls = T_SP_REL;
        else if (hw[15:12] == 4'b1010)                           thm_cls = T_LOAD_ADR;
        else if (hw[15:8] == 8'b1011_0000)                       thm_cls = T_SP_ADJ;
        else if (hw[15:12] == 4'b1011 && hw[10:9] == 2'b10)      thm_cls = T_PUSH_POP;
        else if (hw[15:12] == 4'b1100)                           thm_cls = T_LDM_STM;
        else if (hw[15:8] == 8'b1101_1111)                       thm_cls = T_SWI;
        else if (hw[15:12] == 4'b1101)                           thm_cls = T_COND_BR;
        else if (hw[15:11] == 5'b11100)                          thm_cls = T_B;
        else if (hw[15:12] == 4'b1111)                           thm_cls = T_BL;
        else                                                     thm_cls = T_NONE;
    end

    always_comb begin
        d = '0;
        d.pc_out        = bus.pc_in;
        d.decode_valid  = bus.instr_valid && !bus.flush;
        d.alu_op        = ins[24:21];
        d.rd            = ins[15:12];
        d.rn            = ins[19:16];
        d.rm            = ins[3:0];
        d.shift_type    = ins[6:5];
        d.shift_amount  = ins[11:7];
        d.shift_reg     = ins[4];
        d.shift_rs      = ins[11:8];
        d.branch_offset = ins[23:0];
        d.cp_num        = ins[11:8];
        d.cp_rd         = ins[15:12];
        d.cp_rn         = ins[19:16];
        d.cp_opcode1    = ins[23:21];
        d.cp_opcode2    = ins[7:5];
        if (bus.thumb_mode) begin
            // In Thumb mode, the ARM view is fixed to an always-executed data-processing slot with no flags set.
            d.condition        = 4'hE;
            d.immediate        = ins[11:0];
            d.thumb_instr_type = thm_cls;
            d.thumb_rd         = hw[2:0];
            d.thumb_rs         = hw[5:3];
            d.thumb_rn         = hw[8:6];
            d.thumb_imm8       = hw[7:0];
            d.thumb_imm5       = hw[10:6];
            d.thumb_offset11   = hw[10:0];
            d.thumb_offset8    = hw[7:0];
        end else begin
            d.condition        = ins[31:28];
            d.instr_type       = arm_cls;
            d.thumb_instr_type = T_NONE;
            d.immediate        = (arm_cls == C_HALFWORD_DT) ? {4'h0, ins[11:8], ins[3:0]} : ins[11:0];
            case (arm_cls)
                C_DATA_PROC: begin
                    d.imm_en    = ins[25];
                    d.set_flags = ins[20];
                end
                C_MUL, C_MUL_LONG: d.set_flags = ins[20];
                C_BRANCH_EX:       d.is_branch = 1'b1;
                C_BRANCH: begin
                    d.is_branch   = 1'b1;
                    d.branch_link = ins[24];
                end
                C_SWAP, C_HALFWORD_DT, C_SINGLE_DT, C_BLOCK_DT: begin
                    d.is_memory     = 1'b1;
                    d.mem_load      = ins[20];
                    d.mem_byte      = ins[22];
                    d.mem_pre       = ins[24];
                    d.mem_up        = ins[23];
                    d.mem_writeback = ins[21];
                end
                C_PSR_TRANSFER: begin
                    d.psr_to_reg    = ~ins[21];
                    d.psr_spsr      = ins[22];
                    d.psr_immediate = ins[25];
                end
                C_COPROC_DT: begin
                    d.cp_op   = ins[20] ? 3'd4 : 3'd5;
                    d.cp_load = ins[20];
                end
                C_COPROC_OP: d.cp_op = 3'd1;
                C_COPROC_RT: d.cp_op = ins[20] ? 3'd3 : 3'd2;
                default: ;
            endcase
        end
    end

    // Flush still loads the decoded fields, because d.decode_valid already clears the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (bus.flush || !bus.stall)
            q <= d;
    end

    assign bus.condition        = q.condition;
    assign bus.instr_type       = q.instr_type;
    assign bus.alu_op           = q.alu_op;
    assign bus.rd               = q.rd;
    assign bus.rn               = q.rn;
    assign bus.rm               = q.rm;
    assign bus.immediate        = q.immediate;
    assign bus.imm_en           = q.imm_en;
    assign bus.set_flags        = q.set_flags;
    assign bus.shift_type       = q.shift_type;
    assign bus.shift_amount     = q.shift_amount;
    assign bus.shift_reg        = q.shift_reg;
    assign bus.shift_rs         = q.shift_rs;
    assign bus.is_branch        = q.is_branch;
    assign bus.branch_link      = q.branch_link;
    assign bus.branch_offset    = q.branch_offset;
    assign bus.is_memory        = q.is_memory;
    assign bus.mem_load         = q.mem_load;
    assign bus.mem_byte         = q.mem_byte;
    assign bus.mem_pre          = q.mem_pre;
    assign bus.mem_up           = q.mem_up;
    assign bus.mem_writeback    = q.mem_writeback;
    assign bus.psr_to_reg       = q.psr_to_reg;
    assign bus.psr_spsr         = q.psr_spsr;
    assign bus.psr_immediate    = q.psr_immediate;
    assign bus.cp_op            = q.cp_op;
    assign bus.cp_num           = q.cp_num;
    assign bus.cp_rd            = q.cp_rd;
    assign bus.cp_rn            = q.cp_rn;
    assign bus.cp_opcode1       = q.cp_opcode1;
    assign bus.cp_opcode2       = q.cp_opcode2;
    assign bus.cp_load          = q.cp_load;
    assign bus.thumb_instr_type = q.thumb_instr_type;
    assign bus.thumb_rd         = q.thumb_rd;
    assign bus.thumb_rs         = q.thumb_rs;
    assign bus.thumb_rn         = q.thumb_rn;
    assign bus.thumb_imm8       = q.thumb_imm8;
    assign bus.thumb_imm5       = q.thumb_imm5;
    assign bus.thumb_offset11   = q.thumb_offset11;
    assign bus.thumb_offset8    = q.thumb_offset8;
    assign bus.pc_out           = q.pc_out;
    assign bus.decode_valid     = q.decode_valid;
endmodule

// File: tb/tb_arm7tdmi_decoder.sv
// Testbench for arm7tdmi_decoder. It runs directed and random stimulus against a table-driven reference decoder.
module tb_arm7tdmi_decoder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arm7tdmi_decoder_if bus();
    arm7tdmi_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    typedef struct packed {
        logic [3:0]  condition;
        logic [3:0]  instr_type;
        logic [3:0]  alu_op;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [11:0] immediate;
        logic        imm_en;
        logic        set_flags;
        logic [1:0]  shift_type;
        logic [4:0]  shift_amount;
        logic        shift_reg;
        logic [3:0]  shift_rs;
        logic        is_branch;
        logic        branch_link;
        logic [23:0] branch_offset;
        logic        is_memory;
        logic        mem_load;
        logic        mem_byte;
        logic        mem_pre;
        logic        mem_up;
        logic        mem_writeback;
        logic        psr_to_reg;
        logic        psr_spsr;
        logic        psr_immediate;
        logic [2:0]  cp_op;
        logic [3:0]  cp_num;
        logic [3:0]  cp_rd;
        logic [3:0]  cp_rn;
        logic [2:0]  cp_opcode1;
        logic [2:0]  cp_opcode2;
        logic        cp_load;
        logic [4:0]  thumb_instr_type;
        logic [2:0]  thumb_rd;
        logic [2:0]  thumb_rs;
        logic [2:0]  thumb_rn;
        logic [7:0]  thumb_imm8;
        logic [4:0]  thumb_imm5;
        logic [10:0] thumb_offset11;
        logic [7:0]  thumb_offset8;
        logic [31:0] pc_out;
        logic        decode_valid;
    } dec_t;

    // Each ARM class is described by a mask/match pattern. The list is ordered by priority.
    localparam logic [31:0] ARM_MASK [15] = '{
        32'h0FFF_FFF0, 32'h0FC0_00F0, 32'h0F80_00F0, 32'h0FB0_0FF0, 32'h0E00_0090,
        32'h0D90_0000, 32'h0C00_0000, 32'h0E00_0010, 32'h0C00_0000, 32'h0E00_0000,
        32'h0E00_0000, 32'h0E00_0000, 32'h0F00_0010, 32'h0F00_0010, 32'h0F00_0000};
    localparam logic [31:0] ARM_MATCH [15] = '{
        32'h012F_FF10, 32'h0000_0090, 32'h0080_0090, 32'h0100_0090, 32'h0000_0090,
        32'h0100_0000, 32'h0000_0000, 32'h0600_0010, 32'h0400_0000, 32'h0800_0000,
        32'h0A00_0000, 32'h0C00_0000, 32'h0E00_0000, 32'h0E00_0010, 32'h0F00_0000};
    localparam logic [3:0] ARM_CODE [15] = '{
        4'd4, 4'd1, 4'd2, 4'd3, 4'd5, 4'd14, 4'd0, 4'd7, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};

    localparam logic [15:0] TH_MASK [19] = '{
        16'hF800, 16'hE000, 16'hE000, 16'hFC00, 16'hFC00, 16'hF800, 16'hF200, 16'hF200, 16'hE000, 16'hF000,
        16'hF000, 16'hF000, 16'hFF00, 16'hF600, 16'hFF00, 16'hF000, 16'hF000, 16'hF800, 16'hF000};
    localparam logic [15:0] TH_MATCH [19] = '{
        16'h1800, 16'h0000, 16'h2000, 16'h4000, 16'h4400, 16'h4800, 16'h5000, 16'h5200, 16'h6000, 16'h8000,
        16'h9000, 16'hA000, 16'hB000, 16'hB400, 16'hDF00, 16'hD000, 16'hC000, 16'hE000, 16'hF000};
    localparam logic [4:0] TH_CODE [19] = '{
        5'd1, 5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
        5'd10, 5'd11, 5'd12, 5'd13, 5'd16, 5'd15, 5'd14, 5'd17, 5'd18};

    function automatic logic [3:0] arm_class(input logic [31:0] w);
        for (int k = 0; k < 15; k++)
            if ((w & ARM_MASK[k]) == ARM_MATCH[k]) return ARM_CODE[k];
        return 4'd13;
    endfunction

    function automatic logic [4:0] thumb_class(input logic [15:0] h);
        for (int k = 0; k < 19; k++)
            if ((h & TH_MASK[k]) == TH_MATCH[k]) return TH_CODE[k];
        return 5'd31;
    endfunction

    function automatic dec_t model(input logic [31:0] w, input logic [31:0] pc, input logic th,
                                   input logic iv, input logic fl);
        dec_t e = '0;
        logic [3:0] c;
        e.pc_out = pc;
        e.decode_valid = iv && !fl;
        e.alu_op = w[24:21];  e.rd = w[15:12];  e.rn = w[19:16];  e.rm = w[3:0];
        e.shift_type = w[6:5];  e.shift_amount = w[11:7];  e.shift_reg = w[4];  e.shift_rs = w[11:8];
        e.branch_offset = w[23:0];
        e.cp_num = w[11:8];  e.cp_rd = w[15:12];  e.cp_rn = w[19:16];
        e.cp_opcode1 = w[23:21];  e.cp_opcode2 = w[7:5];
        if (th) begin
            e.condition = 4'hE;
            e.immediate = w[11:0];
            e.thumb_instr_type = thumb_class(w[15:0]);
            e.thumb_rd = w[2:0];  e.thumb_rs = w[5:3];  e.thumb_rn = w[8:6];
            e.thumb_imm8 = w[7:0];  e.thumb_imm5 = w[10:6];
            e.thumb_offset11 = w[10:0];  e.thumb_offset8 = w[7:0];
            return e;
        end
        c = arm_class(w);
        e.condition = w[31:28];
        e.instr_type = c;
        e.thumb_instr_type = 5'd31;
        e.immediate = (c == 4'd5) ? {4'h0, w[11:8], w[3:0]} : w[11:0];
        e.imm_en = (c == 4'd0) && w[25];
        e.set_flags = (c inside {4'd0, 4'd1, 4'd2}) && w[20];
        e.is_branch = c inside {4'd4, 4'd9};
        e.branch_link = (c == 4'd9) && w[24];
        e.is_memory = c inside {4'd3, 4'd5, 4'd6, 4'd8};
        if (e.is_memory) begin
            e.mem_load = w[20];  e.mem_byte = w[22];  e.mem_pre = w[24];
            e.mem_up = w[23];    e.mem_writeback = w[21];
        end
        if (c == 4'd14) begin
            e.psr_to_reg = !w[21];  e.psr_spsr = w[22];  e.psr_immediate = w[25];
        end
        if (c == 4'd10) begin
            e.cp_op = w[20] ? 3'd4 : 3'd5;
            e.cp_load = w[20];
        end
        if (c == 4'd11) e.cp_op = 3'd1;
        if (c == 4'd12) e.cp_op = w[20] ? 3'd3 : 3'd2;
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all(input dec_t e);
        check_val("condition", 32'(bus.condition), 32'(e.condition));
        check_val("instr_type", 32'(bus.instr_type), 32'(e.instr_type));
        check_val("alu_op", 32'(bus.alu_op), 32'(e.alu_op));
        check_val("rd", 32'(bus.rd), 32'(e.rd));
        check_val("rn", 32'(bus.rn), 32'(e.rn));
        check_val("rm", 32'(bus.rm), 32'(e.rm));
        check_val("immediate", 32'(bus.immediate), 32'(e.immediate));
        check_val("imm_en", 32'(bus.imm_en), 32'(e.imm_en));
        check_val("set_flags", 32'(bus.set_flags), 32'(e.set_flags));
        check_val("shift_type", 32'(bus.shift_type), 32'(e.shift_type));
        check_val("shift_amount", 32'(bus.shift_amount), 32'(e.shift_amount));
        check_val("shift_reg", 32'(bus.shift_reg), 32'(e.shift_reg));
        check_val("shift_rs", 32'(bus.shift_rs), 32'(e.shift_rs));
        check_val("is_branch", 32'(bus.is_branch), 32'(e.is_branch));
        check_val("branch_link", 32'(bus.branch_link), 32'(e.branch_link));
        check_val("branch_offset", 32'(bus.branch_offset), 32'(e.branch_offset));
        check_val("is_memory", 32'(bus.is_memory), 32'(e.is_memory));
        check_val("mem_load", 32'(bus.mem_load), 32'(e.mem_load));
        check_val("mem_byte", 32'(bus.mem_byte), 32'(e.mem_byte));
        check_val("mem_pre", 32'(bus.mem_pre), 32'(e.mem_pre));
        check_val("mem_up", 32'(bus.mem_up), 32'(e.mem_up));
        check_val("mem_writeback", 32'(bus.mem_writeback), 32'(e.mem_writeback));
        check_val("psr_to_reg", 32'(bus.psr_to_reg), 32'(e.psr_to_reg));
        check_val("psr_spsr", 32'(bus.psr_spsr), 32'(e.psr_spsr));
        check_val("psr_immediate", 32'(bus.psr_immediate), 32'(e.psr_immediate));
        check_val("cp_op", 32'(bus.cp_op), 32'(e.cp_op));
        check_val("cp_num", 32'(bus.cp_num), 32'(e.cp_num));
        check_val("cp_rd", 32'(bus.cp_rd), 32'(e.cp_rd));
        check_val("cp_rn", 32'(bus.cp_rn), 32'(e.cp_rn));
        check_val("cp_opcode1", 32'(bus.cp_opcode1), 32'(e.cp_opcode1));
        check_val("cp_opcode2", 32'(bus.cp_opcode2), 32'(e.cp_opcode2));
        check_val("cp_load", 32'(bus.cp_load), 32'(e.cp_load));
        check_val("thumb_instr_type", 32'(bus.thumb_instr_type), 32'(e.thumb_instr_type));
        check_val("thumb_rd", 32'(bus.thumb_rd), 32'(e.thumb_rd));
        check_val("thumb_rs", 32'(bus.thumb_rs), 32'(e.thumb_rs));
        check_val("thumb_rn", 32'(bus.thumb_rn), 32'(e.thumb_rn));
        check_val("thumb_imm8", 32'(bus.thumb_imm8), 32'(e.thumb_imm8));
        check_val("thumb_imm5", 32'(bus.thumb_imm5), 32'(e.thumb_imm5));
        check_val("thumb_offset11", 32'(bus.thumb_offset11), 32'(e.thumb_offset11));
        check_val("thumb_offset8", 32'(bus.thumb_offset8), 32'(e.thumb_offset8));
        check_val("pc_out", bus.pc_out, e.pc_out);
        check_val("decode_valid", 32'(bus.decode_valid), 32'(e.decode_valid));
    endtask

    dec_t exp_q = '0;

    task automatic drive(input logic [31:0] w, input logic th, input logic iv, input logic st,
                         input logic fl, input logic [31:0] pc);
        bus.instruction = w;  bus.thumb_mode = th;  bus.instr_valid = iv;
        bus.stall = st;       bus.flush = fl;       bus.pc_in = pc;
    endtask

    // The reference register follows the same flush > stall > load priority as the stage.
    task automatic tick();
        @(posedge clk);
        if (!rst_n)
            exp_q = '0;
        else if (bus.flush || !bus.stall)
            exp_q = model(bus.instruction, bus.pc_in, bus.thumb_mode, bus.instr_valid, bus.flush);
        #1;
        compare_all(exp_q);
    endtask

    task automatic arm_step(input logic [31:0] w);
        drive(w, 1'b0, 1'b1, 1'b0, 1'b0, $urandom);
        tick();
    endtask

    task automatic thumb_step(input logic [15:0] h);
        drive({16'hA5A5, h}, 1'b1, 1'b1, 1'b0, 1'b0, $urandom);
        tick();
    endtask

    task automatic mid_cycle_reset();
        #3 rst_n = 1'b0;
        #1;
        exp_q = '0;
        compare_all(exp_q);
        check_val("rst_valid", 32'(bus.decode_valid), 32'd0);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        logic        th;
        int unsigned k;
        rst_n = 1'b1;
        drive('0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        #1 rst_n = 1'b0;
        #2;
        compare_all(exp_q);
        #10 rst_n = 1'b1;

        arm_step(32'hE12F_FF10);
        check_val("bx_type", 32'(bus.instr_type), 32'd4);
        check_val("bx_branch", 32'(bus.is_branch), 32'd1);
        check_val("bx_rm0", 32'(bus.rm), 32'd0);
        arm_step(32'hE12F_FF11);  check_val("bx_rm1", 32'(bus.rm), 32'd1);
        arm_step(32'hE12F_FF1E);  check_val("bx_rm14", 32'(bus.rm), 32'd14);
        check_val("bx_cond", 32'(bus.condition), 32'hE);

        arm_step(32'hE292_1005);
        check_val("adds_type", 32'(bus.instr_type), 32'd0);
        check_val("adds_alu", 32'(bus.alu_op), 32'd4);
        check_val("adds_imm", 32'(bus.immediate), 32'h005);
        check_val("adds_flags", 32'({bus.imm_en, bus.set_flags}), 32'b11);
        arm_step(32'hE5B1_0004);
        check_val("ldr_type", 32'(bus.instr_type), 32'd6);
        check_val("ldr_mem", 32'({bus.is_memory, bus.mem_load, bus.mem_pre, bus.mem_up, bus.mem_writeback}), 32'b11111);
        arm_step(32'hEB00_0010);
        check_val("bl_type", 32'(bus.instr_type), 32'd9);
        check_val("bl_link", 32'(bus.branch_link), 32'd1);
        check_val("bl_offset", 32'(bus.branch_offset), 32'h10);
        arm_step(32'hE001_0293);  check_val("mul_type", 32'(bus.instr_type), 32'd1);
        arm_step(32'hE102_0091);  check_val("swp_type", 32'(bus.instr_type), 32'd3);
        arm_step(32'hE1D1_00B2);
        check_val("ldrh_type", 32'(bus.instr_type), 32'd5);
        check_val("ldrh_imm", 32'(bus.immediate), 32'h002);
        arm_step(32'hE10F_0000);
        check_val("mrs_type", 32'(bus.instr_type), 32'd14);
        check_val("mrs_to_reg", 32'(bus.psr_to_reg), 32'd1);
        arm_step(32'hEF00_0000);  check_val("swi_type", 32'(bus.instr_type), 32'd13);

        thumb_step(16'h2005);
        check_val("t_imm_type", 32'(bus.thumb_instr_type), 32'd2);
        check_val("t_imm8", 32'(bus.thumb_imm8), 32'h05);
        check_val("t_cond", 32'(bus.condition), 32'hE);
        thumb_step(16'h4770);  check_val("t_bx_type", 32'(bus.thumb_instr_type), 32'd4);
        thumb_step(16'hD0FE);  check_val("t_bcc_type", 32'(bus.thumb_instr_type), 32'd15);
        thumb_step(16'hF000);  check_val("t_bl_type", 32'(bus.thumb_instr_type), 32'd18);

        arm_step(32'hE292_1005);
        drive(32'hE5B1_0004, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        check_val("stall_type", 32'(bus.instr_type), 32'd0);
        check_val("stall_rd", 32'(bus.rd), 32'd1);
        drive(32'hE5B1_0004, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
        tick();
        check_val("flush_valid", 32'(bus.decode_valid), 32'd0);
        drive(32'hE292_1005, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_val("invalid_valid", 32'(bus.decode_valid), 32'd0);
        drive(32'hE292_1005, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100);
        tick();
        check_val("pc_out", bus.pc_out, 32'h100);
        check_val("valid_after", 32'(bus.decode_valid), 32'd1);
        mid_cycle_reset();

        for (int i = 0; i < 600; i++) begin
            th = ($urandom % 4) == 0;
            if (th) begin
                k = $urandom % 20;
                w = $urandom;
                if (k < 19) w[15:0] = TH_MATCH[k] | (w[15:0] & ~TH_MASK[k]);
            end else begin
                k = $urandom % 16;
                w = $urandom;
                if (k < 15) w = ARM_MATCH[k] | (w & ~ARM_MASK[k]) | (w & 32'hF000_0000);
            end
            drive(w, th, ($urandom % 5) != 0, ($urandom % 8) == 0, ($urandom % 8) == 0, $urandom);
            tick();
            if ((i % 150) == 149) mid_cycle_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/arm7tdmi_decoder.md
Name: arm7tdmi_decoder

Overview:
Registered instruction-decode stage of the ARM7TDMI pipeline, sitting between fetch and execute. Each cycle it classifies one fetched word, either a 32-bit ARM instruction or, in Thumb mode, the low 16-bit Thumb instruction. It extracts the operand, shift, memory, PSR, branch and coprocessor fields into pipeline registers. Downstream execute consumes the outputs when decode_valid=1.

Parameters:
None. Widths are fixed by the ISA.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset; asynchronous, active-low
instruction  input  32  fetched word; Thumb uses [15:0]
pc_in  input  32  PC of instruction
instr_valid  input  1  fetch word valid
stall  input  1  hold all outputs
flush  input  1  kill the decoded instruction
thumb_mode  input  1  1=decode Thumb, 0=decode ARM
condition  output  4  ARM [31:28]
instr_type  output  4  class code (see Behaviour)
alu_op  output  4  ARM [24:21]
rd / rn / rm  output  4 each  [15:12] / [19:16] / [3:0]
immediate  output  12  immediate field (see Behaviour)
imm_en / set_flags  output  1 each  [25] / [20]
shift_type / shift_amount / shift_reg / shift_rs  output  2/5/1/4  [6:5] / [11:7] / [4] / [11:8]
is_branch / branch_link / branch_offset  output  1/1/24  B/BL or BX; [24] when BRANCH; [23:0]
is_memory / mem_load / mem_byte / mem_pre / mem_up / mem_writeback  output  1 each  load/store class; [20] / [22] / [24] / [23] / [21]
psr_to_reg / psr_spsr / psr_immediate  output  1 each  MRS(~[21]) / [22] / [25]
cp_op / cp_num / cp_rd / cp_rn / cp_opcode1 / cp_opcode2 / cp_load  output  3/4/4/4/3/3/1  cp_op 0 none,1 CDP,2 MCR,3 MRC,4 LDC,5 STC; [11:8] / [15:12] / [19:16] / [23:21] / [7:5] / [20]
thumb_instr_type  output  5  Thumb format code
thumb_rd / thumb_rs / thumb_rn  output  3 each  [2:0] / [5:3] / [8:6]
thumb_imm8 / thumb_imm5 / thumb_offset11 / thumb_offset8  output  8/5/11/8  [7:0] / [10:6] / [10:0] / [7:0]
pc_out  output  32  registered pc_in
decode_valid  output  1  outputs hold a valid decode

Behaviour:
- One clock domain. Every output is a flop. rst_n low asynchronously clears all outputs to 0.
- Latency 1: values decoded from instruction/pc_in are sampled on a rising edge and appear after that edge.
- Priority: flush > stall > load.
  - flush=1: decode_valid<=0; other outputs load normally.
  - stall=1 (no flush): all outputs hold.
  - Otherwise: all outputs load; decode_valid<=instr_valid.
- ARM instr_type codes, first matching rule wins (bit ranges refer to instruction):
  - [27:4]==24'h12FFF1 -> 4 BRANCH_EX.
  - [27:22]==0 and [7:4]==1001 -> 1 MUL.
  - [27:23]==00001 and [7:4]==1001 -> 2 MUL_LONG.
  - [27:23]==00010, [21:20]==00, [11:4]==00001001 -> 3 SWAP.
  - [27:25]==000, [7]=1, [4]=1 -> 5 HALFWORD_DT.
  - [27:26]==00, [24:23]==10, [20]=0 -> 14 PSR_TRANSFER.
  - [27:26]==00 -> 0 DATA_PROC.
  - [27:25]==011 and [4]=1 -> 7 UNDEFINED.
  - [27:26]==01 -> 6 SINGLE_DT.
  - 100 -> 8 BLOCK_DT; 101 -> 9 BRANCH; 110 -> 10 COPROC_DT.
  - 1110 with [4]=0 -> 11 COPROC_OP; 1110 with [4]=1 -> 12 COPROC_RT.
  - 1111 -> 13 SWI.
- immediate by class:
  - HALFWORD_DT: {4'b0,[11:8],[3:0]}.
  - All other classes: [11:0].
- is_branch=1 for BRANCH and BRANCH_EX. is_memory=1 for SINGLE_DT, HALFWORD_DT, BLOCK_DT, SWAP.
- cp_op=4 for COPROC_DT with [20]=1 and 5 with [20]=0. MCR/MRC are selected by [20].
- Class-specific flags not applicable to the decoded class are 0. Raw field extracts (registers, shift fields) are always driven.
- In ARM mode, thumb_instr_type=31 and the other thumb_* outputs are 0.
- Thumb mode:
  - ARM outputs: condition=4'hE, instr_type=0, all flags 0.
  - Thumb fields are decoded from [15:0].
- thumb_instr_type formats:
  - 0 shift-imm (000, [12:11]!=11); 1 add/sub (00011); 2 imm ops (001).
  - 3 ALU (010000); 4 hi-reg/BX (010001); 5 PC-rel load (01001).
  - 6 reg-offset ld/st (0101,[9]=0); 7 sign-ext ld/st (0101,[9]=1); 8 imm ld/st (011).
  - 9 halfword (1000); 10 SP-rel (1001); 11 load address (1010).
  - 12 SP adjust (10110000); 13 push/pop (1011x10x); 14 ldm/stm (1100).
  - 15 cond branch (1101, cond!=1111); 16 SWI (11011111); 17 B (11100); 18 BL (1111).
  - Anything else -> 31.
- Changing thumb_mode takes effect on the next sampled edge; there is no internal state beyond the output registers.

Test Plan:
- Reset: rst_n=0 mid-cycle -> all outputs 0 immediately, decode_valid=0.
- ARM BX: instruction=E12FFF10, 11, 1E -> after one edge instr_type=4, is_branch=1, rm=0/1/14, condition=E.
- ARM ADDS R1,R2,#5 (E2921005) -> instr_type=0, alu_op=4, imm_en=1, set_flags=1, rd=1, rn=2, immediate=005. LDR R0,[R1,#4]! (E5B10004) -> instr_type=6, is_memory=1, mem_load=1, mem_pre=1, mem_up=1, mem_writeback=1. BL (EB000010) -> instr_type=9, branch_link=1, branch_offset=000010.
- Class boundaries: MUL E0010293 -> 1; SWP E1020091 -> 3; LDRH E1D100B2 -> 5 with immediate=002; MRS E10F0000 -> 14 with psr_to_reg=1; SWI EF000000 -> 13.
- Thumb: thumb_mode=1, instruction[15:0] set to 2005 / 4770 / D0FE / F000 -> thumb_instr_type=2 / 4 / 15 / 18; for 2005, thumb_imm8=05.
- Control: stall=1 holds previous outputs while the instruction changes. flush=1 -> decode_valid=0 next edge. instr_valid=0 -> decode_valid=0. pc_in=100 -> pc_out=100 after one edge.
